// File: rtl/unidade_controle.sv
// Control unit for the class-distribution phase: seed selection, then a hidden/shown/next
// reveal cycle per player, driving the fluxo_dados seed and player counters.
module unidade_controle #(
    parameter int T_MOSTRA = 50_000_000,
    parameter int W_TIMER  = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       confirma,
    input  logic       CJ_fim,
    output logic       zera_CS,
    output logic       e_seed_reg,
    output logic       zera_CJ,
    output logic       inc_jogador,
    output logic       mostra_classe,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        ESCOLHE_SEED   = 4'd1,
        CARREGA_SEED   = 4'd2,
        ZERA_JOGADOR   = 4'd3,
        ESPERA_JOGADOR = 4'd4,
        MOSTRA         = 4'd5,
        PROXIMO        = 4'd6,
        FIM            = 4'd7
    } estado_t;

    localparam logic [W_TIMER-1:0] TIMER_MAX = W_TIMER'(T_MOSTRA - 1);

    estado_t            estado;
    estado_t            proximo;
    logic               conf_prev;
    logic               conf_pulso;
    logic               timeout;
    logic [W_TIMER-1:0] timer;

    // conf_prev resets high so a button held through reset never looks like a fresh press
    always_ff @(posedge clock) begin
        if (reset) begin
            conf_prev <= 1'b1;
        end else begin
            conf_prev <= confirma;
        end
    end

    assign conf_pulso = confirma & ~conf_prev;

    always_ff @(posedge clock) begin
        if (reset || estado != MOSTRA) begin
            timer <= '0;
        end else begin
            timer <= timer + W_TIMER'(1);
        end
    end

    assign timeout = (timer == TIMER_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:        proximo = iniciar ? ESCOLHE_SEED : INICIAL;
            ESCOLHE_SEED:   proximo = conf_pulso ? CARREGA_SEED : ESCOLHE_SEED;
            CARREGA_SEED:   proximo = ZERA_JOGADOR;
            ZERA_JOGADOR:   proximo = ESPERA_JOGADOR;
            ESPERA_JOGADOR: proximo = conf_pulso ? MOSTRA : ESPERA_JOGADOR;
            MOSTRA:         proximo = (conf_pulso || timeout) ? PROXIMO : MOSTRA;
            PROXIMO:        proximo = CJ_fim ? FIM : ESPERA_JOGADOR;
            FIM:            proximo = iniciar ? INICIAL : FIM;
            default:        proximo = INICIAL;
        endcase
    end

    // inc_jogador is the only Mealy term: it must stay low on the last player
    always_comb begin
        zera_CS       = 1'b0;
        e_seed_reg    = 1'b0;
        zera_CJ       = 1'b0;
        inc_jogador   = 1'b0;
        mostra_classe = 1'b0;
        pronto        = 1'b0;
        case (estado)
            INICIAL: begin
                zera_CS = 1'b1;
                zera_CJ = 1'b1;
            end
            CARREGA_SEED: e_seed_reg    = 1'b1;
            ZERA_JOGADOR: zera_CJ       = 1'b1;
            MOSTRA:       mostra_classe = 1'b1;
            PROXIMO:      inc_jogador   = ~CJ_fim;
            FIM:          pronto        = 1'b1;
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule
